instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Front-end fetch stage between the instruction cache and the out-of-order core's decode/dispatch. Generates sequential fetch addresses and drives the i-cache read handshake, one request outstanding at a time. Buffers returned instructions with their PCs in a circular queue that the core drains. Redirects on a core flush, discarding any in-flight response.

## Interface
- DEPTH, 8: instruction queue entries; power of two, ≥2.
- RESET_PC, 32'h4000_0000: first fetch address after reset.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- instr_read  out  1  read request to i-cache; held until instr_mem_resp.
- instr_mem_address  out  32  fetch address; stable while instr_read=1.
- instr_mem_resp  in  1  i-cache response, one-cycle pulse.
- instr_mem_rdata  in  32  instruction word; valid with instr_mem_resp.
- iq_valid  out  1  queue head holds an instruction.
- iq_instr  out  32  head instruction.
- iq_pc  out  32  head PC.
- iq_ready  in  1  core dequeues head this cycle (ignored when iq_valid=0).
- flush  in  1  redirect: clear queue, restart at flush_pc.
- flush_pc  in  32  redirect target; 4-byte aligned.

## Operation
- State: fetch_pc (32), redirect_pc (32), head/tail (log2 DEPTH), count (log2 DEPTH + 1), FSM {IDLE, REQ, DISCARD}.
- Reset: IDLE, fetch_pc=RESET_PC, count=head=tail=0; outputs instr_read=0, instr_mem_address=RESET_PC, iq_valid=0, iq_instr/iq_pc don't-care.
- instr_read=1 in REQ and DISCARD; instr_mem_address=fetch_pc always.
- IDLE: count<DEPTH and !flush → REQ.
- REQ, resp, !flush: enqueue {fetch_pc, rdata} at tail; fetch_pc+=4 (32-bit wrap); stay REQ if post-update count<DEPTH, else IDLE.
- REQ, !resp, flush: → DISCARD; fetch_pc held (address must not change mid-request); redirect_pc=flush_pc.
- REQ, resp, flush: response dropped; fetch_pc=flush_pc; → REQ.
- IDLE, flush: fetch_pc=flush_pc; → REQ.
- DISCARD: flush updates redirect_pc. On resp: data dropped, fetch_pc = flush_pc if flush else redirect_pc; → REQ. No enqueue in DISCARD.
- Queue: iq_valid=(count!=0); iq_instr/iq_pc from head entry combinationally. Dequeue on iq_valid&iq_ready. Enqueue and dequeue same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Flush: count, head, tail → 0 regardless of simultaneous enqueue/dequeue; flush has priority.
- Overflow impossible: a request issues only with a free slot, and only one is outstanding.

## Timing
- Response in cycle N → iq_valid=1, iq_instr=rdata in N+1.
- After reset deassert: IDLE one cycle, instr_read=1 from cycle 1.
- Back-to-back: instr_read stays high across resp; next address presented cycle after resp.
- Flush in cycle N: iq_valid=0 in N+1; new address presented N+1 (no request in flight) or the cycle after the discarded response.
- Full queue: instr_read=0 from cycle after filling; dequeue in cycle M → IDLE→REQ, instr_read=1 in M+2.
- rst mid-request: immediate return to reset values; the i-cache is reset by the same rst.

## Structure
- fetch_entry_t {rv32i_word pc; rv32i_word instr;} goes in rv32i_types; RESET_PC stays a parameter.
- Sub-module fetch_queue: DEPTH-entry ring buffer of fetch_entry_t with enq/deq/clear, count, head outputs. Top holds FSM and PC logic.

## Test plan
- Reset, 1-cycle-latency cache: addresses 0x40000000, 04, 08… back-to-back; first iq_valid cycle after first resp with iq_pc=0x40000000.
- iq_ready=0, DEPTH=8: exactly 8 responses accepted, instr_read=0 after 8th; one dequeue → one more request at 0x40000020.
- Flush(flush_pc=0x40000100) while request at 0x40000010 pending 5 cycles: address held at 0x40000010 until resp, data not enqueued, next request 0x40000100, iq_valid=0 meanwhile.
- Flush coincident with resp and dequeue, count=3: count=0 next cycle, next address=flush_pc, response dropped.
- Second flush (0x200) during DISCARD after first (0x100): fetch resumes at 0x200.
- Simultaneous enq/deq at count=DEPTH-1 across pointer wrap: order preserved, count constant, iq_pc increments by 4 each dequeue.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and constants for the RV32I fetch front end.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

    // Fetch FSM encodings.
    localparam logic [1:0] FETCH_IDLE    = 2'd0;
    localparam logic [1:0] FETCH_REQ     = 2'd1;
    localparam logic [1:0] FETCH_DISCARD = 2'd2;

    // Sequential successor of a fetch address (wraps at 2^32).
    function automatic rv32i_word next_seq_pc(input rv32i_word pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Ring buffer of fetched instructions with enqueue, dequeue and clear.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enq,
    input  fetch_entry_t  enq_data,
    input  logic          deq,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          deq_fire;
    fetch_entry_t  mem_q [DEPTH];

    assign deq_fire = deq && (count_q != '0);

    // Pointer/occupancy update; clear overrides any concurrent enq/deq.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq)      tail_d = tail_q + PW'(1);
            if (deq_fire) head_d = head_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(deq_fire);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= enq_data;
    end

    assign count = count_q;
    assign head  = mem_q[head_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential PC generation, single-outstanding i-cache
// handshake, instruction queue toward decode, and flush redirect.
module instr_fetch_unit
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        instr_read,
    output logic [31:0] instr_mem_address,
    input  logic        instr_mem_resp,
    input  logic [31:0] instr_mem_rdata,
    output logic        iq_valid,
    output logic [31:0] iq_instr,
    output logic [31:0] iq_pc,
    input  logic        iq_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]    state_q, state_d;
    rv32i_word     fetch_pc_q, fetch_pc_d;
    rv32i_word     redirect_pc_q, redirect_pc_d;
    logic          enq;
    logic          deq;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_enq;
    fetch_entry_t  enq_data;
    fetch_entry_t  head;

    assign deq             = iq_valid & iq_ready;
    assign count_after_enq = count + CW'(1) - CW'(deq);
    assign enq_data        = '{pc: fetch_pc_q, instr: instr_mem_rdata};

    // Next-state, fetch address and redirect target selection.
    // A flush during an outstanding request parks the target in redirect_pc
    // so the address stays stable until the stale response returns.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        enq           = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (flush) begin
                    fetch_pc_d = flush_pc;
                    state_d    = FETCH_REQ;
                end else if (count < DEPTH_C) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (instr_mem_resp && !flush) begin
                    enq        = 1'b1;
                    fetch_pc_d = next_seq_pc(fetch_pc_q);
                    state_d    = (count_after_enq < DEPTH_C) ? FETCH_REQ : FETCH_IDLE;
                end else if (instr_mem_resp && flush) begin
                    fetch_pc_d = flush_pc;
                end else if (flush) begin
                    redirect_pc_d = flush_pc;
                    state_d       = FETCH_DISCARD;
                end
            end
            FETCH_DISCARD: begin
                if (flush) redirect_pc_d = flush_pc;
                if (instr_mem_resp) begin
                    fetch_pc_d = flush ? flush_pc : redirect_pc_q;
                    state_d    = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // FSM and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_IDLE;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .enq      (enq),
        .enq_data (enq_data),
        .deq      (deq),
        .count    (count),
        .head     (head)
    );

    assign instr_read        = (state_q != FETCH_IDLE);
    assign instr_mem_address = fetch_pc_q;
    assign iq_valid          = (count != '0);
    assign iq_instr          = head.instr;
    assign iq_pc             = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: the bench acts as the
// i-cache and the core, predicts fetch behaviour at transaction level and
// checks dequeued instructions in a separate monitor.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam int          NCYC     = 700;
    localparam int          RST_AT   = 520;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;
    logic        iq_valid;
    logic [31:0] iq_instr;
    logic [31:0] iq_pc;
    logic        iq_ready;
    logic        flush;
    logic [31:0] flush_pc;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_read        (instr_read),
        .instr_mem_address (instr_mem_address),
        .instr_mem_resp    (instr_mem_resp),
        .instr_mem_rdata   (instr_mem_rdata),
        .iq_valid          (iq_valid),
        .iq_instr          (iq_instr),
        .iq_pc             (iq_pc),
        .iq_ready          (iq_ready),
        .flush             (flush),
        .flush_pc          (flush_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and counters
    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_deq   = 0;
    bit   done    = 1'b0;

    // Reference model of the fetch engine
    logic        m_read;    // a request is being presented
    logic [31:0] m_addr;    // address being / to be fetched
    logic        m_drop;    // in-flight response belongs to a flushed path
    logic [31:0] m_target;  // where fetch resumes after the dropped response
    int          lat;       // cycles until the i-cache answers

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_read   = 1'b0;
        m_addr   = RESET_PC;
        m_drop   = 1'b0;
        m_target = RESET_PC;
        lat      = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        chk("instr_read", 32'(instr_read), 32'(m_read));
        chk("instr_mem_address", instr_mem_address, m_addr);
        chk("iq_valid", 32'(iq_valid), 32'(exp_q.size() != 0));
    endtask

    // Predicts the effect of one clock edge with the given inputs.
    task automatic model_step(input logic resp, input logic [31:0] data,
                              input logic fl, input logic [31:0] fpc, input logic rdy);
        int   cnt;
        int   dq;
        exp_t e;
        cnt = exp_q.size();
        dq  = (rdy && cnt != 0) ? 1 : 0;
        if (!m_read) begin
            if (fl) begin
                m_addr = fpc;
                m_read = 1'b1;
            end else if (cnt < DEPTH) begin
                m_read = 1'b1;
            end
        end else if (!m_drop) begin
            if (resp && !fl) begin
                e.pc    = m_addr;
                e.instr = data;
                exp_q.push_back(e);
                m_addr = m_addr + 32'd4;
                m_read = ((cnt + 1 - dq) < DEPTH);
            end else if (resp && fl) begin
                m_addr = fpc;
            end else if (fl) begin
                m_drop   = 1'b1;
                m_target = fpc;
            end
        end else begin
            if (fl) m_target = fpc;
            if (resp) begin
                m_addr = m_target;
                m_drop = 1'b0;
            end
        end
    endtask

    // Driver: i-cache responder, core ready, flush generator, cycle checks.
    initial begin
        int          max_lat;
        int          rdy_pct;
        int          fl_div;
        logic        resp;
        logic        fl;
        logic        rdy;
        logic [31:0] fpc;
        logic [31:0] data;

        rst             = 1'b1;
        instr_mem_resp  = 1'b0;
        instr_mem_rdata = '0;
        iq_ready        = 1'b0;
        flush           = 1'b0;
        flush_pc        = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        for (int i = 0; i < NCYC; i++) begin
            if (i == RST_AT) begin
                iq_ready       = 1'b0;
                flush          = 1'b0;
                instr_mem_resp = 1'b0;
                #3 rst = 1'b1;
                #1;
                model_reset();
                check_outputs();
                @(negedge clk);
                rst = 1'b0;
            end

            // fill with no drain, then light drain, then full-rate
            // streaming across pointer wrap, then random mix with flushes
            if (i < 30) begin
                max_lat = 0; rdy_pct = 0;   fl_div = 0;
            end else if (i < 60) begin
                max_lat = 0; rdy_pct = 25;  fl_div = 0;
            end else if (i < 120) begin
                max_lat = 0; rdy_pct = 100; fl_div = 0;
            end else begin
                max_lat = 5; rdy_pct = 50;  fl_div = 7;
            end

            resp = 1'b0;
            if (m_read) begin
                if (lat == 0) begin
                    resp = 1'b1;
                    lat  = $urandom_range(0, max_lat);
                end else begin
                    lat--;
                end
            end
            data = $urandom;
            rdy  = ($urandom_range(1, 100) <= rdy_pct);
            fl   = (fl_div != 0) && ($urandom_range(0, fl_div - 1) == 0);
            case ($urandom_range(0, 3))
                0:       fpc = 32'h4000_0100;
                1:       fpc = 32'h4000_0200;
                2:       fpc = 32'h4000_0000 | ($urandom & 32'h0000_0FFC);
                default: fpc = 32'hFFFF_FFF8;
            endcase

            model_step(resp, data, fl, fpc, rdy);

            instr_mem_resp  = resp;
            instr_mem_rdata = data;
            iq_ready        = rdy;
            flush           = fl;
            flush_pc        = fpc;

            @(negedge clk);
            check_outputs();
        end

        instr_mem_resp = 1'b0;
        iq_ready       = 1'b0;
        flush          = 1'b0;
        done           = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("dequeues_seen", 32'(n_deq > 50), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Monitor: compares every dequeued head against the scoreboard.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (iq_valid && iq_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("deq_expected_entry", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("iq_pc", iq_pc, e.pc);
                        chk("iq_instr", iq_instr, e.instr);
                        n_deq++;
                    end
                end
                if (flush) exp_q.delete();
            end
        end
    end

endmodule
